// File: rtl/count_timer_pkg.sv
// Shared definitions for the count_timer_ctrl block.
//   state_t   : controller state encoding (IDLE / RUN / PAUSED)
//   WIDTH_DEF : default counter / load-value width in bits
package count_timer_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

endpackage : count_timer_pkg

// File: rtl/count_timer_ctrl_load_up_counter.sv
// load_up_counter: loadable WIDTH-bit up-counter.
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous active-low reset, clears q to 0
//   load  in  : load din into the counter (wins over en)
//   en    in  : increment by one this cycle
//   din   in  : load value
//   q     out : current counter value
module load_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = din;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : load_up_counter

// File: rtl/count_timer_ctrl.sv
// count_timer_ctrl: programmable interval timer built around load_up_counter.
// Loads a start value, counts qualified ticks up to all-ones, pulses expire,
// then either stops (one-shot) or reloads the captured period (periodic).
//   clk         in  : clock, rising edge
//   rst_n       in  : synchronous active-low reset
//   start       in  : 1-cycle request, capture load_val/mode_reload and (re)start
//   stop        in  : 1-cycle request, abort to IDLE (beats start)
//   pause       in  : level, freezes counting while high
//   mode_reload in  : 0 = one-shot, 1 = periodic, sampled with start
//   load_val    in  : start value, period = MAX - load_val + 1 ticks
//   tick_en     in  : count qualifier
//   busy        out : high in RUN or PAUSED
//   expire      out : registered 1-cycle pulse after a terminal tick
//   count       out : current counter value
module count_timer_ctrl
    import count_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic             tick_en,
    output logic             busy,
    output logic             expire,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           state_d, state_q;
    logic             expire_d, expire_q;
    logic [WIDTH-1:0] period_d, period_q;
    logic             mode_d, mode_q;

    logic             cnt_load;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_din;
    logic [WIDTH-1:0] count_q;

    load_up_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .en    (cnt_en),
        .din   (cnt_din),
        .q     (count_q)
    );

    // Event priority: stop > start > pause > terminal tick > normal tick.
    // A terminal tick replaces the MAX->0 wrap: either reload the period or
    // hold at MAX and drop to IDLE.
    always_comb begin
        state_d  = state_q;
        expire_d = 1'b0;
        period_d = period_q;
        mode_d   = mode_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_din  = period_q;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            period_d = load_val;
            mode_d   = mode_reload;
            cnt_load = 1'b1;
            cnt_din  = load_val;
            state_d  = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (tick_en) begin
                        if (count_q == MAX) begin
                            expire_d = 1'b1;
                            if (mode_q) begin
                                cnt_load = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            cnt_en = 1'b1;
                        end
                    end
                end
                // Leaving PAUSED does not count; the next tick_en does.
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            expire_q <= 1'b0;
            period_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            expire_q <= expire_d;
            period_q <= period_d;
            mode_q   <= mode_d;
        end
    end

    assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign expire = expire_q;
    assign count  = count_q;

endmodule : count_timer_ctrl

// File: tb/tb_count_timer_ctrl.sv
module tb_count_timer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       mode_reload;
    logic [3:0] load_val;
    logic       tick_en;
    logic       busy;
    logic       expire;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    count_timer_ctrl #(
        .WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .mode_reload (mode_reload),
        .load_val    (load_val),
        .tick_en     (tick_en),
        .busy        (busy),
        .expire      (expire),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int c, input int b, input int e);
        chk({tag, ".count"},  32'(count),  32'(c));
        chk({tag, ".busy"},   32'(busy),   32'(b));
        chk({tag, ".expire"}, 32'(expire), 32'(e));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode_reload = 1'b0; load_val = 4'd0; tick_en = 1'b1;

        // Reset
        cyc(); cyc();
        chk3("reset", 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        chk3("idle_after_reset", 0, 0, 0);

        // One-shot from 6
        start = 1'b1; load_val = 4'd6; mode_reload = 1'b0;
        cyc();
        start = 1'b0;
        chk3("os_start", 6, 1, 0);
        for (int i = 7; i <= 15; i++) begin
            cyc();
            chk3($sformatf("os_cnt%0d", i), i, 1, 0);
        end
        cyc();
        chk3("os_expire", 15, 0, 1);
        cyc();
        chk3("os_after", 15, 0, 0);

        // Periodic from 6
        start = 1'b1; load_val = 4'd6; mode_reload = 1'b1;
        cyc();
        start = 1'b0;
        chk3("per_start", 6, 1, 0);
        for (int i = 7; i <= 15; i++) begin
            cyc();
            chk3($sformatf("per_a%0d", i), i, 1, 0);
        end
        cyc();
        chk3("per_exp1", 6, 1, 1);
        for (int i = 7; i <= 15; i++) begin
            cyc();
            chk3($sformatf("per_b%0d", i), i, 1, 0);
        end
        cyc();
        chk3("per_exp2", 6, 1, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk3("per_stop", 6, 0, 0);

        // tick_en 1-in-3, one-shot from 13
        tick_en = 1'b0;
        start = 1'b1; load_val = 4'd13; mode_reload = 1'b0;
        cyc();
        start = 1'b0;
        chk3("tk_start", 13, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            tick_en = (k % 3 == 0);
            cyc();
            chk3($sformatf("tk_k%0d", k), 13 + ((k / 3) > 2 ? 2 : (k / 3)), 1, 0);
        end
        tick_en = 1'b1;
        cyc();
        chk3("tk_expire", 15, 0, 1);

        // Pause at 9, then stop at 12
        start = 1'b1; load_val = 4'd6; mode_reload = 1'b0;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        chk3("pz_at9", 9, 1, 0);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk3($sformatf("pz_hold%0d", i), 9, 1, 0);
        end
        pause = 1'b0;
        cyc();
        chk3("pz_release", 9, 1, 0);
        cyc();
        chk3("pz_resume", 10, 1, 0);
        cyc(); cyc();
        chk3("pz_at12", 12, 1, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk3("stop_at12", 12, 0, 0);
        cyc();
        chk3("stop_hold", 12, 0, 0);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1; load_val = 4'd2;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk3("startstop_idle", 12, 0, 0);

        // Restart during terminal tick in periodic mode
        start = 1'b1; load_val = 4'd12; mode_reload = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        chk3("rs_at15", 15, 1, 0);
        start = 1'b1; load_val = 4'd3;
        cyc();
        start = 1'b0;
        chk3("rs_restart", 3, 1, 0);
        for (int i = 4; i <= 15; i++) begin
            cyc();
            chk3($sformatf("rs_cnt%0d", i), i, 1, 0);
        end
        cyc();
        chk3("rs_expire", 3, 1, 1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // load_val = MAX, periodic: expire every cycle
        start = 1'b1; load_val = 4'd15; mode_reload = 1'b1;
        cyc();
        start = 1'b0;
        chk3("max_start", 15, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk3($sformatf("max_exp%0d", i), 15, 1, 1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk3("max_stop", 15, 0, 0);

        // Reset mid-run at 11
        start = 1'b1; load_val = 4'd6; mode_reload = 1'b0;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk3("rst_at11", 11, 1, 0);
        rst_n = 1'b0;
        cyc();
        chk3("rst_mid", 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        chk3("rst_after", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_count_timer_ctrl
